riscv_boot_sequencer: RTL and testbench



---
 rtl/riscv_boot_pkg.sv | 28 ++
 rtl/word2byte_serializer.sv | 94 +++++++++
 rtl/riscv_boot_sequencer.sv | 159 +++++++++++++++
 tb/tb_riscv_boot_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_boot_pkg.sv
// Shared definitions for the RISC-V boot sequencer: command opcodes, FSM states, error bits.
// The optional checksum stage is enabled with RISCV_BOOT_CSUM_EN.
package riscv_boot_pkg;

  localparam logic [3:0] OP_LOAD   = 4'h1;
  localparam logic [3:0] OP_START  = 4'h2;
  localparam logic [3:0] OP_HALT   = 4'h3;
  localparam logic [3:0] OP_CLRERR = 4'h4;

  localparam int ERR_OPCODE = 0;
  localparam int ERR_RANGE  = 1;
  localparam int ERR_CSUM   = 2;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_LEN  = 3'd1,
    GET_DATA = 3'd2,
    WRITE    = 3'd3,
    GET_CSUM = 3'd4
  } state_e;

  function automatic logic [3:0] opcode_of(input logic [31:0] word);
    return word[31:28];
  endfunction

endpackage

// File: rtl/word2byte_serializer.sv
// Splits a 32-bit program word into four little-endian byte writes on the
// instruction-memory config bus, dropping writes beyond MEM_SIZE.
module word2byte_serializer
  import riscv_boot_pkg::*;
#(
  parameter int          ADDR_BITS = 24,
  parameter int unsigned MEM_SIZE  = 32768
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 set_base_i,
  input  logic [ADDR_BITS-1:0] base_i,
  input  logic                 load_i,
  input  logic [31:0]          word_i,
  input  logic                 step_i,
  output logic                 done_o,
  output logic                 oor_o,
  output logic [ADDR_BITS-1:0] addr_o,
  output logic [7:0]           byte_o,
  output logic                 wr_en_o
);

  localparam logic [2:0] LAST_B = 3'(BYTES_PER_WORD);

  logic [23:0]          shreg_q, shreg_d;
  logic [2:0]           b_q, b_d;
  logic [ADDR_BITS-1:0] ptr_q, ptr_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [7:0]           byte_q, byte_d;
  logic                 wr_en_q, wr_en_d;
  logic                 emit;
  logic [7:0]           emit_byte;
  logic                 in_range;

  assign in_range = 32'(ptr_q) < MEM_SIZE;

  // Byte 0 is emitted straight from the incoming word so the first strobe
  // lands in the cycle right after the word is accepted.
  always_comb begin
    shreg_d   = shreg_q;
    b_d       = b_q;
    ptr_d     = ptr_q;
    addr_d    = addr_q;
    byte_d    = byte_q;
    wr_en_d   = 1'b0;
    emit      = 1'b0;
    emit_byte = shreg_q[7:0];
    if (set_base_i) begin
      ptr_d = base_i;
    end
    if (load_i) begin
      emit      = 1'b1;
      emit_byte = word_i[7:0];
      shreg_d   = word_i[31:8];
      b_d       = 3'd1;
    end else if (step_i && (b_q != LAST_B)) begin
      emit      = 1'b1;
      emit_byte = shreg_q[7:0];
      shreg_d   = shreg_q >> 8;
      b_d       = b_q + 3'd1;
    end
    if (emit) begin
      addr_d  = ptr_q;
      byte_d  = emit_byte;
      wr_en_d = in_range;
      ptr_d   = ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shreg_q <= '0;
      b_q     <= '0;
      ptr_q   <= '0;
      addr_q  <= '0;
      byte_q  <= '0;
      wr_en_q <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      b_q     <= b_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      byte_q  <= byte_d;
      wr_en_q <= wr_en_d;
    end
  end

  assign done_o  = (b_q == LAST_B);
  assign oor_o   = emit & ~in_range;
  assign addr_o  = addr_q;
  assign byte_o  = byte_q;
  assign wr_en_o = wr_en_q;

endmodule

// File: rtl/riscv_boot_sequencer.sv
// Command-stream boot loader for picorv32_wrapper: loads program bytes and gates core reset.
// Define RISCV_BOOT_CSUM_EN to require a trailing checksum word after each load.
module riscv_boot_sequencer
  import riscv_boot_pkg::*;
#(
  parameter int          ADDR_BITS = 24,
  parameter int unsigned MEM_SIZE  = 32768,
  parameter int          LEN_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [31:0]          din,
  input  logic                 val_in,
  output logic                 ready_upward,
  input  logic                 ap_start,
  output logic [ADDR_BITS-1:0] instr_config_addr,
  output logic [7:0]           instr_config_din,
  output logic                 instr_config_wr_en,
  output logic                 core_resetn,
  output logic                 busy,
  output logic [2:0]           err
);

  // Stream handshake: a word moves when val_in && ready_upward at a rising
  // clk edge; ready_upward depends only on state, never on val_in.

`ifdef RISCV_BOOT_CSUM_EN
  localparam state_e DONE_STATE = GET_CSUM;
  logic [31:0] sum_q, sum_d;
`else
  localparam state_e DONE_STATE = IDLE;
`endif

  state_e              state_q, state_d;
  logic [LEN_BITS-1:0] cnt_q, cnt_d;
  logic                run_q, run_d;
  logic [2:0]          err_q, err_d;
  logic                core_q;
  logic                xfer;
  logic                set_base;
  logic                load;
  logic                step;
  logic                ser_done;
  logic                ser_oor;

  assign ready_upward = (state_q != WRITE);
  assign xfer         = val_in & ready_upward;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    err_d    = err_q;
    set_base = 1'b0;
    load     = 1'b0;
    step     = 1'b0;
`ifdef RISCV_BOOT_CSUM_EN
    sum_d    = sum_q;
`endif
    case (state_q)
      IDLE: begin
        if (xfer) begin
          case (opcode_of(din))
            OP_LOAD: begin
              set_base = 1'b1;
              run_d    = 1'b0;
`ifdef RISCV_BOOT_CSUM_EN
              sum_d    = '0;
`endif
              state_d  = GET_LEN;
            end
            OP_START:  if (!err_q[ERR_CSUM]) run_d = 1'b1;
            OP_HALT:   run_d = 1'b0;
            OP_CLRERR: err_d = '0;
            default:   err_d[ERR_OPCODE] = 1'b1;
          endcase
        end
      end
      GET_LEN: begin
        if (xfer) begin
          cnt_d   = din[LEN_BITS-1:0];
          state_d = (din[LEN_BITS-1:0] == '0) ? DONE_STATE : GET_DATA;
        end
      end
      GET_DATA: begin
        if (xfer) begin
          load    = 1'b1;
`ifdef RISCV_BOOT_CSUM_EN
          sum_d   = sum_q + din;
`endif
          state_d = WRITE;
        end
      end
      WRITE: begin
        step = 1'b1;
        if (ser_done) begin
          cnt_d   = cnt_q - LEN_BITS'(1);
          state_d = (cnt_q == LEN_BITS'(1)) ? DONE_STATE : GET_DATA;
        end
      end
`ifdef RISCV_BOOT_CSUM_EN
      GET_CSUM: begin
        if (xfer) begin
          if (din != sum_q) err_d[ERR_CSUM] = 1'b1;
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    if (ser_oor) err_d[ERR_RANGE] = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      err_q   <= '0;
      core_q  <= 1'b0;
`ifdef RISCV_BOOT_CSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      err_q   <= err_d;
      // ap_start low holds the core in reset without forgetting a START.
      core_q  <= run_q & ap_start;
`ifdef RISCV_BOOT_CSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  word2byte_serializer #(
    .ADDR_BITS (ADDR_BITS),
    .MEM_SIZE  (MEM_SIZE)
  ) u_ser (
    .clk        (clk),
    .resetn     (resetn),
    .set_base_i (set_base),
    .base_i     (din[ADDR_BITS-1:0]),
    .load_i     (load),
    .word_i     (din),
    .step_i     (step),
    .done_o     (ser_done),
    .oor_o      (ser_oor),
    .addr_o     (instr_config_addr),
    .byte_o     (instr_config_din),
    .wr_en_o    (instr_config_wr_en)
  );

  assign core_resetn = core_q;
  assign busy        = (state_q != IDLE);
  assign err         = err_q;

endmodule

// File: tb/tb_riscv_boot_sequencer.sv
// Bench for riscv_boot_sequencer: command vector table, hand-written load/abort
// sequences and randomized traffic against a transaction-level memory/flag model.
module tb_riscv_boot_sequencer;

  localparam int          ADDR_BITS = 24;
  localparam int unsigned MEM_SIZE  = 32768;
  localparam int          LEN_BITS  = 16;

  logic                 clk = 1'b0;
  logic                 resetn;
  logic [31:0]          din;
  logic                 val_in;
  logic                 ready_upward;
  logic                 ap_start;
  logic [ADDR_BITS-1:0] cfg_addr;
  logic [7:0]           cfg_din;
  logic                 cfg_wr_en;
  logic                 core_resetn;
  logic                 busy;
  logic [2:0]           err;

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  riscv_boot_sequencer #(
    .ADDR_BITS (ADDR_BITS),
    .MEM_SIZE  (MEM_SIZE),
    .LEN_BITS  (LEN_BITS)
  ) dut (
    .clk                (clk),
    .resetn             (resetn),
    .din                (din),
    .val_in             (val_in),
    .ready_upward       (ready_upward),
    .ap_start           (ap_start),
    .instr_config_addr  (cfg_addr),
    .instr_config_din   (cfg_din),
    .instr_config_wr_en (cfg_wr_en),
    .core_resetn        (core_resetn),
    .busy               (busy),
    .err                (err)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  int          wr_cnt = 0;
  int          rdy_low_run = 0;
  logic        m_run = 1'b0;
  logic [2:0]  m_err = 3'b000;
  logic [31:0] data_buf[8];

  typedef struct {
    logic [31:0] word;
    logic        ap;
    logic [2:0]  exp_err;
    logic        exp_core;
  } vec_t;
  vec_t vt[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // scoreboard: every observed strobe must match the next expected (addr, byte)
  always @(negedge clk) begin
    if (!resetn) begin
      rdy_low_run = 0;
    end else begin
      if (cfg_wr_en) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual=%h expected=none", {cfg_addr, cfg_din});
        end else begin
          chk("write", {cfg_addr, cfg_din}, exp_q.pop_front());
        end
      end
      if (!ready_upward) begin
        rdy_low_run++;
      end else if (rdy_low_run != 0) begin
        chk("ready_low_cycles", 32'(rdy_low_run), 32'd4);
        rdy_low_run = 0;
      end
    end
  end

  // driver tasks
  task automatic send_word(input logic [31:0] w);
    int n;
    n = 0;
    @(negedge clk);
    din    = w;
    val_in = 1'b1;
    while (!ready_upward && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready_upward) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=ready_low expected=ready_high");
    end else begin
      @(posedge clk);
    end
    #1;
    val_in = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle_timeout actual=busy expected=idle");
    end
  endtask

  // reference model: the image a load should leave in memory, byte by byte
  task automatic model_load(input logic [23:0] base, input int len, input logic bad);
    logic [31:0] full;
    logic [31:0] a;
    logic [7:0]  by;
    m_run = 1'b0;
    for (int i = 0; i < len; i++) begin
      for (int k = 0; k < 4; k++) begin
        full = {8'h00, base} + 32'(4 * i + k);
        a    = full % (32'd1 << ADDR_BITS);
        by   = 8'(data_buf[i] >> (8 * k));
        if (a < MEM_SIZE) exp_q.push_back({a[23:0], by});
        else m_err[1] = 1'b1;
      end
    end
`ifdef RISCV_BOOT_CSUM_EN
    if (bad) m_err[2] = 1'b1;
`else
    if (bad) m_err[2] = 1'b0;
`endif
  endtask

  task automatic do_load(input logic [23:0] base, input int len, input logic bad);
    logic [31:0] sum;
    sum = 32'h0;
    model_load(base, len, bad);
    send_word({8'h10, base});
    send_word(32'(len));
    for (int i = 0; i < len; i++) begin
      send_word(data_buf[i]);
      sum = sum + data_buf[i];
      if (i == 0) begin
        chk("first_wr_en", {31'h0, cfg_wr_en}, {31'h0, ({8'h00, base} < MEM_SIZE)});
        chk("ready_in_write", {31'h0, ready_upward}, 32'h0);
        if ({8'h00, base} < MEM_SIZE)
          chk("first_byte", {cfg_addr, cfg_din}, {base, data_buf[0][7:0]});
      end
    end
`ifdef RISCV_BOOT_CSUM_EN
    send_word(sum + {31'h0, bad});
`endif
    wait_idle();
  endtask

  task automatic do_cmd(input logic [3:0] op);
    case (op)
      4'h2:    if (!m_err[2]) m_run = 1'b1;
      4'h3:    m_run = 1'b0;
      4'h4:    m_err = 3'b000;
      default: m_err[0] = 1'b1;
    endcase
    send_word({op, 28'h0});
  endtask

  task automatic check_status(input string name);
    repeat (2) @(negedge clk);
    chk({name, "_err"}, {29'h0, err}, {29'h0, m_err});
    chk({name, "_core"}, {31'h0, core_resetn}, {31'h0, m_run & ap_start});
    chk({name, "_pending"}, 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    logic [23:0] base;
    int          len;
    int          sel;
    logic [3:0]  op;

    resetn   = 1'b0;
    din      = '0;
    val_in   = 1'b0;
    ap_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'h0, ready_upward}, 32'h1);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_wr_en", {31'h0, cfg_wr_en}, 32'h0);
    chk("rst_core", {31'h0, core_resetn}, 32'h0);
    chk("rst_err", {29'h0, err}, 32'h0);
    chk("rst_bus", {cfg_addr, cfg_din}, 32'h0);
    resetn = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'h0, ready_upward}, 32'h1);

    // two-word load at 0x100
    data_buf[0] = 32'h44332211;
    data_buf[1] = 32'h88776655;
    wr_cnt = 0;
    do_load(24'h000100, 2, 1'b0);
    chk("load1_strobes", 32'(wr_cnt), 32'd8);
    chk("load1_busy", {31'h0, busy}, 32'h0);
    check_status("load1");

    // START gated by ap_start, one-cycle lag
    ap_start = 1'b1;
    do_cmd(4'h2);
    chk("start_lag", {31'h0, core_resetn}, 32'h0);
    @(posedge clk); #1;
    chk("start_core", {31'h0, core_resetn}, 32'h1);
    ap_start = 1'b0;
    @(posedge clk); #1;
    chk("ap_drop_core", {31'h0, core_resetn}, 32'h0);
    ap_start = 1'b1;
    @(posedge clk); #1;
    chk("ap_raise_core", {31'h0, core_resetn}, 32'h1);

    // load straddling the end of memory
    data_buf[0] = 32'hDDCCBBAA;
    wr_cnt = 0;
    do_load(24'h007FFE, 1, 1'b0);
    chk("edge_strobes", 32'(wr_cnt), 32'd2);
    chk("edge_err", {29'h0, err}, 32'h2);
    check_status("edge");

    // reset asserted during the second byte of a word
    data_buf[0] = 32'h44332211;
    m_run = 1'b0;
    exp_q.push_back({24'h007000, 8'h11});
    send_word(32'h10007000);
    send_word(32'h1);
    send_word(data_buf[0]);
    @(posedge clk); #2;
    chk("abort_pre_wr_en", {31'h0, cfg_wr_en}, 32'h1);
    chk("abort_pre_err", {29'h0, err}, 32'h2);
    resetn = 1'b0;
    #1;
    chk("abort_wr_en", {31'h0, cfg_wr_en}, 32'h0);
    chk("abort_core", {31'h0, core_resetn}, 32'h0);
    chk("abort_busy", {31'h0, busy}, 32'h0);
    m_run = 1'b0;
    m_err = 3'b000;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("abort_ready", {31'h0, ready_upward}, 32'h1);
    chk("abort_err", {29'h0, err}, 32'h0);
    chk("abort_pending", 32'(exp_q.size()), 32'h0);

    // command vector table
    vt[0]  = '{32'h20000000, 1'b1, 3'b000, 1'b1};
    vt[1]  = '{32'h20000000, 1'b0, 3'b000, 1'b0};
    vt[2]  = '{32'h40000000, 1'b1, 3'b000, 1'b1};
    vt[3]  = '{32'hF0000000, 1'b1, 3'b001, 1'b1};
    vt[4]  = '{32'h50000000, 1'b1, 3'b001, 1'b1};
    vt[5]  = '{32'h40000000, 1'b1, 3'b000, 1'b1};
    vt[6]  = '{32'h30000000, 1'b1, 3'b000, 1'b0};
    vt[7]  = '{32'h00000000, 1'b0, 3'b001, 1'b0};
    vt[8]  = '{32'h20000000, 1'b0, 3'b001, 1'b0};
    vt[9]  = '{32'h20000000, 1'b1, 3'b001, 1'b1};
    vt[10] = '{32'h40000000, 1'b1, 3'b000, 1'b1};
    vt[11] = '{32'h30000000, 1'b1, 3'b000, 1'b0};
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      ap_start = vt[i].ap;
      do_cmd(vt[i].word[31:28]);
      repeat (2) @(negedge clk);
      chk("vec_err", {29'h0, err}, {29'h0, vt[i].exp_err});
      chk("vec_core", {31'h0, core_resetn}, {31'h0, vt[i].exp_core});
      chk("vec_busy", {31'h0, busy}, 32'h0);
    end

`ifdef RISCV_BOOT_CSUM_EN
    ap_start = 1'b1;
    data_buf[0] = 32'h00000005;
    do_load(24'h000000, 1, 1'b1);
    chk("csum_bad_err", {29'h0, err}, 32'h4);
    do_cmd(4'h2);
    repeat (2) @(negedge clk);
    chk("csum_bad_core", {31'h0, core_resetn}, 32'h0);
    do_cmd(4'h4);
    do_load(24'h000000, 1, 1'b0);
    do_cmd(4'h2);
    repeat (2) @(negedge clk);
    chk("csum_ok_core", {31'h0, core_resetn}, 32'h1);
    check_status("csum");
`endif

    // randomized traffic against the model
    for (int it = 0; it < 30; it++) begin
      @(negedge clk);
      ap_start = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 5);
      if (sel <= 1) begin
        case ($urandom_range(0, 2))
          0:       base = 24'($urandom_range(0, 32'h7F00));
          1:       base = 24'($urandom_range(32'h7FF0, 32'h8008));
          default: base = 24'($urandom_range(32'hFFFFF0, 32'hFFFFFF));
        endcase
        len = $urandom_range(0, 3);
        for (int i = 0; i < len; i++) data_buf[i] = $urandom;
        do_load(base, len, 1'($urandom_range(0, 1)));
      end else if (sel == 2) begin
        do_cmd(4'h2);
      end else if (sel == 3) begin
        do_cmd(4'h3);
      end else if (sel == 4) begin
        do_cmd(4'h4);
      end else begin
        op = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(5, 15));
        do_cmd(op);
      end
      check_status("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
